// File: rtl/clk_pulse_gen.sv
// clk_pulse_gen: programmable clock generator with phase offset, high/low times and a one-deep config slot.
// All outputs are registered from the FSM state, so clk_out trails its state by one clk cycle.
module clk_pulse_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_phase,
  input  logic [CNT_W-1:0] cfg_ton,
  input  logic [CNT_W-1:0] cfg_toff,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             rise,
  output logic             fall,
  output logic             running
);
  typedef enum logic [1:0] {IDLE, PHASE, HIGH, LOW} state_t;
  state_t state_q;
  logic [CNT_W-1:0] cnt_q, ph_q, ton_q, toff_q, pph_q, pton_q, ptoff_q;
  logic [CNT_W-1:0] ph_e, ton_e;
  logic pend_q, clk_out_q, rise_q, fall_q, err_q, run_q;
  logic cfg_ok, cfg_bad, bound, apply;
  assign cfg_ready = !pend_q;
  assign cfg_ok    = cfg_valid && !pend_q && cfg_ton != '0 && cfg_toff != '0;
  assign cfg_bad   = cfg_valid && !pend_q && (cfg_ton == '0 || cfg_toff == '0);
  assign bound     = state_q == LOW && en && cnt_q == '0;
  // pending config only lands while idle or exactly at a period boundary
  assign apply     = pend_q && (state_q == IDLE || bound);
  assign ph_e      = apply ? pph_q : ph_q;
  assign ton_e     = apply ? pton_q : ton_q;
  assign cfg_err   = err_q;
  assign clk_out   = clk_out_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign running   = run_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ph_q      <= '0;
      ton_q     <= CNT_W'(1);
      toff_q    <= CNT_W'(1);
      pph_q     <= '0;
      pton_q    <= '0;
      ptoff_q   <= '0;
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      err_q     <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      clk_out_q <= state_q == HIGH;
      rise_q    <= state_q == HIGH && !clk_out_q;
      fall_q    <= state_q != HIGH && clk_out_q;
      run_q     <= state_q != IDLE;
      err_q     <= cfg_bad;
      if (apply) begin
        ph_q   <= pph_q;
        ton_q  <= pton_q;
        toff_q <= ptoff_q;
        pend_q <= 1'b0;
      end
      if (cfg_ok) begin
        pph_q   <= cfg_phase;
        pton_q  <= cfg_ton;
        ptoff_q <= cfg_toff;
        pend_q  <= 1'b1;
      end
      case (state_q)
        IDLE: if (en) begin
          state_q <= ph_e != '0 ? PHASE : HIGH;
          cnt_q   <= ph_e != '0 ? ph_e - 1'b1 : ton_e - 1'b1;
        end
        PHASE: if (!en) state_q <= IDLE;
          else if (cnt_q == '0) begin
            state_q <= HIGH;
            cnt_q   <= ton_q - 1'b1;
          end else cnt_q <= cnt_q - 1'b1;
        HIGH: if (cnt_q == '0) begin
            state_q <= LOW;
            cnt_q   <= toff_q - 1'b1;
          end else cnt_q <= cnt_q - 1'b1;
        default: if (!en) state_q <= IDLE;
          else if (cnt_q == '0) begin
            state_q <= HIGH;
            cnt_q   <= ton_e - 1'b1;
          end else cnt_q <= cnt_q - 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_clk_pulse_gen.sv
// tb_clk_pulse_gen: directed checks of clk_pulse_gen timing, config handshake, stop and reset behaviour.
module tb_clk_pulse_gen;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, cfg_valid = 1'b0;
  logic [15:0] cfg_phase = '0, cfg_ton = '0, cfg_toff = '0;
  logic cfg_ready, cfg_err, clk_out, rise, fall, running;
  int n_chk = 0, n_fail = 0, hc;
  always #5 clk = ~clk;
  clk_pulse_gen #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_phase(cfg_phase), .cfg_ton(cfg_ton), .cfg_toff(cfg_toff), .cfg_err(cfg_err),
    .clk_out(clk_out), .rise(rise), .fall(fall), .running(running)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic load(input logic [15:0] p, input logic [15:0] t, input logic [15:0] f);
    cfg_phase = p; cfg_ton = t; cfg_toff = f; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    step(2);
    chk("rst_clk", clk_out, 0); chk("rst_rise", rise, 0); chk("rst_fall", fall, 0);
    chk("rst_err", cfg_err, 0); chk("rst_run", running, 0); chk("rst_ready", cfg_ready, 1);
    rst = 1'b0;
    step(1);
    load(2, 3, 7);
    chk("t1_ready_pend", cfg_ready, 0);
    step(1);
    chk("t1_ready_free", cfg_ready, 1);
    en = 1'b1;
    for (int i = 0; i < 53; i++) begin
      @(negedge clk);
      chk("t1_clk", clk_out, i >= 3 && (i - 3) % 10 < 3);
      chk("t1_rise", rise, i >= 3 && (i - 3) % 10 == 0);
      chk("t1_fall", fall, i >= 6 && (i - 6) % 10 == 0);
      if (i == 5) chk("t1_run", running, 1);
    end
    en = 1'b0;
    step(12);
    chk("t2_stop_clk", clk_out, 0); chk("t2_stop_run", running, 0);
    cfg_phase = 0; cfg_ton = 0; cfg_toff = 5; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("t2_err", cfg_err, 1); chk("t2_err_ready", cfg_ready, 1);
    step(1);
    chk("t2_err_once", cfg_err, 0); chk("t2_ready", cfg_ready, 1); chk("t2_clk", clk_out, 0);
    load(0, 1, 1);
    step(1);
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_tog_clk", clk_out, i % 2 == 1);
      chk("t2_tog_rise", rise, i % 2 == 1);
      chk("t2_tog_fall", fall, i >= 2 && i % 2 == 0);
    end
    en = 1'b0;
    step(4);
    load(0, 4, 4);
    step(1);
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t3_clk", clk_out, (i >= 1 && i <= 4) || (i >= 9 && i <= 10) || (i >= 17 && i <= 18));
      chk("t3_ready", cfg_ready, !(i >= 3 && i <= 7));
      if (i == 2) begin
        cfg_phase = 0; cfg_ton = 2; cfg_toff = 6; cfg_valid = 1'b1;
      end
      if (i == 3) cfg_valid = 1'b0;
    end
    en = 1'b0;
    step(12);
    load(0, 5, 3);
    step(1);
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("t4_clk", clk_out, i >= 1 && i <= 5);
      chk("t4_rise", rise, i == 1);
      chk("t4_fall", fall, i == 6);
      chk("t4_run", running, i >= 1 && i <= 6);
      if (i == 1) en = 1'b0;
    end
    en = 1'b1;
    step(2);
    chk("t5_pre_clk", clk_out, 1);
    cfg_phase = 0; cfg_ton = 3; cfg_toff = 3; cfg_valid = 1'b1;
    step(1);
    chk("t5_pend", cfg_ready, 0); chk("t5_mid_clk", clk_out, 1);
    cfg_valid = 1'b0; en = 1'b0; rst = 1'b1;
    #1;
    chk("t5_async_clk", clk_out, 0); chk("t5_async_run", running, 0);
    chk("t5_async_ready", cfg_ready, 1);
    step(1);
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t5_dflt_clk", clk_out, i % 2 == 1);
    end
    en = 1'b0;
    step(4);
    load(0, 16'hFFFF, 1);
    step(1);
    en = 1'b1;
    hc = 0;
    for (int i = 0; i < 65538; i++) begin
      @(negedge clk);
      if (i >= 1 && i <= 65535) hc += int'(clk_out);
      if (i == 0) chk("t6_start", clk_out, 0);
      if (i == 65536) begin
        chk("t6_low", clk_out, 0); chk("t6_fall", fall, 1);
      end
      if (i == 65537) begin
        chk("t6_again", clk_out, 1); chk("t6_rise", rise, 1);
      end
    end
    chk("t6_high_len", hc, 65535);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
